// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, dmem wait stalls, branch/jump flushes,
// operand forwarding selects (or RAW stalling when forwarding is disabled) and halt.
module hazard_ctrl #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned LU_STALLS = 1,
    parameter int unsigned FWD_EN    = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ihit_i,
    input  logic              dhit_i,
    input  logic              xmem_memreq_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              halt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic [REG_AW-1:0] idex_rs_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic [REG_AW-1:0] xmem_rd_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic              idex_memread_i,
    input  logic              idex_regwrite_i,
    input  logic              xmem_regwrite_i,
    input  logic              mwb_regwrite_i,
    output logic              pc_en_o,
    output logic              stall_ifid_o,
    output logic              stall_idex_o,
    output logic              stall_xmem_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              flush_xmem_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {StRun, StLuStall, StHalt} state_e;

    localparam logic [1:0] LuInit = 2'(LU_STALLS - 1);

    state_e             state_q, state_d;
    logic [1:0]         lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic lu_hit, raw_hit, dw, hz_stall, halting;

    function automatic logic raw_src(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] d_rd,
                                     input logic d_we, input logic [REG_AW-1:0] m_rd,
                                     input logic m_we);
        return (src != '0) && ((d_we && d_rd == src) || (m_we && m_rd == src));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] m_rd, input logic m_we,
                                           input logic [REG_AW-1:0] w_rd, input logic w_we);
        if (m_we && m_rd != '0 && m_rd == src) return 2'b10;
        if (w_we && w_rd != '0 && w_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    assign lu_hit  = idex_memread_i && (idex_rd_i != '0) &&
                     (idex_rd_i == ifid_rs_i || idex_rd_i == ifid_rt_i);
    assign raw_hit = raw_src(ifid_rs_i, idex_rd_i, idex_regwrite_i, xmem_rd_i, xmem_regwrite_i) ||
                     raw_src(ifid_rt_i, idex_rd_i, idex_regwrite_i, xmem_rd_i, xmem_regwrite_i);
    assign dw       = xmem_memreq_i && !dhit_i;
    assign hz_stall = (FWD_EN != 0) ? lu_hit : raw_hit;
    assign halting  = (state_q == StHalt) || halt_i;

    // Control outputs depend on the current inputs so hazards are covered in the same cycle.
    always_comb begin
        pc_en_o      = 1'b1;
        stall_ifid_o = 1'b0;
        stall_idex_o = 1'b0;
        stall_xmem_o = 1'b0;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        flush_xmem_o = 1'b0;
        halted_o     = 1'b0;
        if (rst_i) begin
            pc_en_o      = 1'b0;
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end else if (halting) begin
            pc_en_o      = 1'b0;
            stall_ifid_o = 1'b1;
            stall_idex_o = 1'b1;
            stall_xmem_o = 1'b1;
            halted_o     = 1'b1;
        end else if (dw) begin
            pc_en_o      = 1'b0;
            stall_ifid_o = 1'b1;
            stall_idex_o = 1'b1;
            stall_xmem_o = 1'b1;
        end else if (branch_taken_i) begin
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end else if (state_q == StLuStall || hz_stall) begin
            pc_en_o      = 1'b0;
            stall_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
        end else if (jump_i) begin
            flush_ifid_o = 1'b1;
        end else if (!ihit_i) begin
            pc_en_o      = 1'b0;
            flush_ifid_o = 1'b1;
        end
    end

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (FWD_EN != 0 && !rst_i) begin
            fwd_a_o = fwd_sel(idex_rs_i, xmem_rd_i, xmem_regwrite_i, mwb_rd_i, mwb_regwrite_i);
            fwd_b_o = fwd_sel(idex_rt_i, xmem_rd_i, xmem_regwrite_i, mwb_rd_i, mwb_regwrite_i);
        end
    end

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        if (halting) begin
            state_d = StHalt;
        end else if (dw) begin
            state_d = state_q;
        end else if (branch_taken_i) begin
            state_d  = StRun;
            lu_cnt_d = 2'd0;
        end else if (state_q == StLuStall) begin
            // The cycle with lu_cnt==1 is the last bubble of this hazard.
            if (lu_cnt_q <= 2'd1) begin
                state_d  = StRun;
                lu_cnt_d = 2'd0;
            end else begin
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end else if (FWD_EN != 0 && lu_hit && LU_STALLS > 1) begin
            state_d  = StLuStall;
            lu_cnt_d = LuInit;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && state_q != StHalt && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            lu_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dut_a forwards with two load-use bubbles; dut_b stalls on RAW, 2-bit counter.
module tb_hazard_ctrl;

    logic       clk, rst;
    logic       ihit, dhit, xmem_memreq, branch_taken, jump, halt;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, xmem_rd, mwb_rd;
    logic       idex_memread, idex_regwrite, xmem_regwrite, mwb_regwrite;

    logic        a_pc_en, a_s_ifid, a_s_idex, a_s_xmem, a_f_ifid, a_f_idex, a_f_xmem, a_halted;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_cnt;
    logic        b_pc_en, b_s_ifid, b_s_idex, b_s_xmem, b_f_ifid, b_f_idex, b_f_xmem, b_halted;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [1:0]  b_cnt;

    logic [7:0] a_ctl, b_ctl;
    logic [3:0] a_fwd, b_fwd;
    assign a_ctl = {a_pc_en, a_s_ifid, a_s_idex, a_s_xmem, a_f_ifid, a_f_idex, a_f_xmem, a_halted};
    assign b_ctl = {b_pc_en, b_s_ifid, b_s_idex, b_s_xmem, b_f_ifid, b_f_idex, b_f_xmem, b_halted};
    assign a_fwd = {a_fwd_a, a_fwd_b};
    assign b_fwd = {b_fwd_a, b_fwd_b};

    // {pc_en, stall_ifid, stall_idex, stall_xmem, flush_ifid, flush_idex, flush_xmem, halted}
    localparam logic [7:0] CtlDef = 8'b1000_0000;
    localparam logic [7:0] CtlRst = 8'b0000_1100;
    localparam logic [7:0] CtlHlt = 8'b0111_0001;
    localparam logic [7:0] CtlDw  = 8'b0111_0000;
    localparam logic [7:0] CtlBr  = 8'b1000_1100;
    localparam logic [7:0] CtlLu  = 8'b0100_0100;
    localparam logic [7:0] CtlJmp = 8'b1000_1000;
    localparam logic [7:0] CtlIms = 8'b0000_1000;

    hazard_ctrl #(.REG_AW(5), .LU_STALLS(2), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .dhit_i(dhit), .xmem_memreq_i(xmem_memreq),
        .branch_taken_i(branch_taken), .jump_i(jump), .halt_i(halt),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .idex_rs_i(idex_rs), .idex_rt_i(idex_rt),
        .idex_rd_i(idex_rd), .xmem_rd_i(xmem_rd), .mwb_rd_i(mwb_rd),
        .idex_memread_i(idex_memread), .idex_regwrite_i(idex_regwrite),
        .xmem_regwrite_i(xmem_regwrite), .mwb_regwrite_i(mwb_regwrite),
        .pc_en_o(a_pc_en), .stall_ifid_o(a_s_ifid), .stall_idex_o(a_s_idex),
        .stall_xmem_o(a_s_xmem), .flush_ifid_o(a_f_ifid), .flush_idex_o(a_f_idex),
        .flush_xmem_o(a_f_xmem), .fwd_a_o(a_fwd_a), .fwd_b_o(a_fwd_b), .halted_o(a_halted),
        .stall_cnt_o(a_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .LU_STALLS(1), .FWD_EN(0), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .dhit_i(dhit), .xmem_memreq_i(xmem_memreq),
        .branch_taken_i(branch_taken), .jump_i(jump), .halt_i(halt),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .idex_rs_i(idex_rs), .idex_rt_i(idex_rt),
        .idex_rd_i(idex_rd), .xmem_rd_i(xmem_rd), .mwb_rd_i(mwb_rd),
        .idex_memread_i(idex_memread), .idex_regwrite_i(idex_regwrite),
        .xmem_regwrite_i(xmem_regwrite), .mwb_regwrite_i(mwb_regwrite),
        .pc_en_o(b_pc_en), .stall_ifid_o(b_s_ifid), .stall_idex_o(b_s_idex),
        .stall_xmem_o(b_s_xmem), .flush_ifid_o(b_f_ifid), .flush_idex_o(b_f_idex),
        .flush_xmem_o(b_f_xmem), .fwd_a_o(b_fwd_a), .fwd_b_o(b_fwd_b), .halted_o(b_halted),
        .stall_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        ihit = 1'b1; dhit = 1'b1; xmem_memreq = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        halt = 1'b0;
        ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0; idex_rd = '0;
        xmem_rd = '0; mwb_rd = '0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; xmem_regwrite = 1'b0; mwb_regwrite = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        halt = 1'b1; xmem_rd = 5'd5; xmem_regwrite = 1'b1; idex_rs = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", a_ctl, CtlRst);
        check("rst_fwd", a_fwd, 4'b0000);
        check("rst_cnt", a_cnt, 0);
        clear();
        rst = 1'b0;
        #1;
        check("idle_ctl", a_ctl, CtlDef);

        // Load-use with two bubbles; the load leaves EX after the first one.
        idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
        #1 check("lu_b1", a_ctl, CtlLu);
        tick();
        clear();
        #1 check("lu_b2", a_ctl, CtlLu);
        tick();
        check("lu_done", a_ctl, CtlDef);
        check("lu_cnt", a_cnt, 2);

        // Forwarding priority and register 0.
        xmem_rd = 5'd5; xmem_regwrite = 1'b1; mwb_rd = 5'd5; mwb_regwrite = 1'b1; idex_rs = 5'd5;
        #1 check("fwd_exmem", a_fwd, 4'b1000);
        xmem_rd = 5'd0;
        #1 check("fwd_memwb", a_fwd, 4'b0100);
        idex_rt = 5'd5; idex_rs = 5'd0; xmem_rd = 5'd5;
        #1 check("fwd_b", a_fwd, 4'b0010);
        clear();
        xmem_regwrite = 1'b1; mwb_regwrite = 1'b1; idex_memread = 1'b1;
        #1 check("r0_fwd", a_fwd, 4'b0000);
        check("r0_lu", a_ctl, CtlDef);
        clear();

        // Dmem wait in the middle of a load-use sequence.
        idex_memread = 1'b1; idex_rd = 5'd3; ifid_rt = 5'd3;
        #1 check("lu2_b1", a_ctl, CtlLu);
        tick();
        clear();
        xmem_memreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("dw_ctl", a_ctl, CtlDw);
            tick();
        end
        clear();
        #1 check("lu2_b2", a_ctl, CtlLu);
        tick();
        check("lu2_done", a_ctl, CtlDef);
        check("dw_cnt", a_cnt, 7);

        // Branch overrides a fresh load-use and an in-progress bubble sequence.
        idex_memread = 1'b1; idex_rd = 5'd4; ifid_rs = 5'd4; branch_taken = 1'b1;
        #1 check("br_lu", a_ctl, CtlBr);
        tick();
        clear();
        #1 check("br_lu_next", a_ctl, CtlDef);
        idex_memread = 1'b1; idex_rd = 5'd4; ifid_rs = 5'd4;
        tick();
        clear();
        branch_taken = 1'b1;
        #1 check("br_lus", a_ctl, CtlBr);
        tick();
        clear();
        #1 check("br_lus_next", a_ctl, CtlDef);
        check("br_cnt", a_cnt, 8);

        // Jump, icache miss, dmem wait over branch.
        jump = 1'b1;
        #1 check("jmp", a_ctl, CtlJmp);
        ihit = 1'b0;
        #1 check("jmp_over_ims", a_ctl, CtlJmp);
        jump = 1'b0;
        #1 check("ims", a_ctl, CtlIms);
        tick();
        clear();
        xmem_memreq = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        #1 check("dw_over_br", a_ctl, CtlDw);
        tick();
        clear();
        #1 check("misc_cnt", a_cnt, 10);

        // Halt is sticky; the halt-request cycle itself still counts as a stall.
        halt = 1'b1;
        #1 check("halt_ctl", a_ctl, CtlHlt);
        tick();
        clear();
        branch_taken = 1'b1;
        repeat (4) tick();
        check("halt_hold", a_ctl, CtlHlt);
        check("halt_cnt", a_cnt, 11);
        clear();
        rst = 1'b1;
        #1 check("arst_ctl", a_ctl, CtlRst);
        check("arst_cnt", a_cnt, 0);
        rst = 1'b0;
        #1 check("post_halt", a_ctl, CtlDef);

        // Asynchronous reset while in the bubble state.
        idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
        tick();
        clear();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("arst_lus", a_ctl, CtlDef);
        tick();

        // RAW stalling without forwarding.
        idex_rd = 5'd7; idex_regwrite = 1'b1; ifid_rt = 5'd7;
        idex_rs = 5'd7; mwb_rd = 5'd7; mwb_regwrite = 1'b1;
        #1 check("raw_idex", b_ctl, CtlLu);
        check("raw_fwd0", b_fwd, 4'b0000);
        check("fwd_nostall", a_ctl, CtlDef);
        check("fwd_on_a", a_fwd, 4'b0100);
        tick();
        idex_rd = 5'd0; idex_regwrite = 1'b0;
        #1 check("raw_1cyc", b_ctl, CtlDef);
        check("raw_cnt1", b_cnt, 1);
        xmem_rd = 5'd7; xmem_regwrite = 1'b1;
        #1 check("raw_xmem", b_ctl, CtlLu);
        check("raw_fwd0b", b_fwd, 4'b0000);
        check("fwd_pri_a", a_fwd, 4'b1000);
        tick();
        clear();
        idex_regwrite = 1'b1; xmem_regwrite = 1'b1;
        #1 check("raw_r0", b_ctl, CtlDef);
        check("raw_cnt2", b_cnt, 2);

        // 2-bit stall counter saturates.
        clear();
        ihit = 1'b0;
        tick();
        check("sat_3", b_cnt, 3);
        repeat (2) tick();
        check("sat_hold", b_cnt, 3);
        clear();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use parameter REG_AW, default 5, as the register-index width.
REQ-002 The block SHALL use parameter LU_STALLS, default 1, range 1..3, as the bubble count per load-use hazard.
REQ-003 The block SHALL use parameter FWD_EN, default 1; 1 enables forwarding selects, 0 resolves RAW hazards by stalling.
REQ-004 The block SHALL use parameter CNT_W, default 16, as the stall-counter width.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high; ports: CLK in 1 clock; RST in 1 reset.
REQ-006 The block SHALL have inputs: ihit 1 imem ready; dhit 1 dmem ready; xmem_memreq 1 load/store in MEM; branch_taken 1 resolved in EX; jump 1 in ID; halt 1 halt in WB.
REQ-007 The block SHALL have inputs: ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, xmem_rd, mwb_rd (REG_AW each); idex_memread, idex_regwrite, xmem_regwrite, mwb_regwrite (1 each).
REQ-008 The block SHALL have outputs: pc_en, stall_ifid, stall_idex, stall_xmem, flush_ifid, flush_idex, flush_xmem (1 each); fwd_a, fwd_b (2 each); halted 1; stall_cnt CNT_W.

Function
REQ-009 Defs: LU = idex_memread && idex_rd!=0 && (idex_rd==ifid_rs || idex_rd==ifid_rt); DW = xmem_memreq && !dhit.
REQ-010 State machine SHALL have states RUN, LU_STALL, HALT; a down-counter lu_cnt of 2 bits.
REQ-011 Default outputs, no event: pc_en=1; all stall_* and flush_* 0; fwd from REQ-018.
REQ-012 Priority, highest first: HALT, DW, branch_taken, LU (or RAW stall if FWD_EN=0), jump, !ihit.
REQ-013 HALT state, or halt=1 in any state: pc_en=0, stall_ifid=stall_idex=stall_xmem=1, halted=1, next state HALT; exit only via RST.
REQ-014 DW: pc_en=0, stall_ifid=stall_idex=stall_xmem=1, flush_xmem=0; state and lu_cnt hold.
REQ-015 branch_taken: pc_en=1, flush_ifid=flush_idex=1; next state RUN, lu_cnt=0, overriding LU/LU_STALL.
REQ-016 LU in RUN: pc_en=0, stall_ifid=1, flush_idex=1 that cycle; if LU_STALLS>1 next LU_STALL with lu_cnt=LU_STALLS-1, else stay RUN.
REQ-017 LU_STALL: same outputs as REQ-016; lu_cnt decrements; return to RUN in the cycle lu_cnt==1; total bubbles per hazard = LU_STALLS exactly.
REQ-018 FWD_EN=1: fwd_a=2'b10 if xmem_regwrite && xmem_rd!=0 && xmem_rd==idex_rs; else 2'b01 if mwb_regwrite && mwb_rd!=0 && mwb_rd==idex_rs; else 2'b00; fwd_b identically on idex_rt; EX/MEM wins over MEM/WB.
REQ-019 FWD_EN=0: fwd_a=fwd_b=2'b00; RAW stall when ifid_rs or ifid_rt (nonzero) equals idex_rd with idex_regwrite or xmem_rd with xmem_regwrite: outputs as REQ-016, no LU_STALL entry, re-evaluated each cycle.
REQ-020 jump (no higher event): flush_ifid=1, pc_en=1.
REQ-021 !ihit (no higher event): pc_en=0, flush_ifid=1.
REQ-022 stall_cnt SHALL increment each cycle pc_en==0 and state!=HALT, saturating at all-ones, never wrapping.
REQ-023 Register 0 SHALL never cause a hazard or forward.

Reset
REQ-024 While RST=1: state RUN, lu_cnt=0, stall_cnt=0, halted=0, pc_en=0, flush_ifid=flush_idex=1, other stalls/flushes 0, fwd 00.
REQ-025 RST assertion mid-LU_STALL, mid-DW or in HALT SHALL take effect asynchronously; first post-reset cycle is RUN.

Verification
REQ-026 LU_STALLS=2, load to r3 in EX, ifid_rs=3 -> pc_en=0, flush_idex=1 for exactly 2 cycles, then RUN; stall_cnt=2.
REQ-027 xmem_rd=5 xmem_regwrite=1, mwb_rd=5 mwb_regwrite=1, idex_rs=5 -> fwd_a=2'b10; xmem_rd=0 instead -> fwd_a=2'b01.
REQ-028 In LU_STALL, xmem_memreq=1 dhit=0 for 3 cycles -> all stalls 1, lu_cnt held; after dhit=1 remaining bubbles complete.
REQ-029 branch_taken=1 with LU=1 same cycle -> flush_ifid=flush_idex=1, pc_en=1, next state RUN.
REQ-030 halt=1 -> halted=1 and pc_en=0 indefinitely, stall_cnt frozen; RST pulse -> halted=0, stall_cnt=0.
REQ-031 FWD_EN=0, idex_rd=7 idex_regwrite=1, ifid_rt=7 -> 1-cycle stall; fwd_a=fwd_b=2'b00 always.
